// File: rtl/fetch_unit.sv
// Decoupled fetch stage: owns the fetch PC, issues valid/ready imem requests, and queues returned words for decode.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty (0-cycle latency).
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH      = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_resp_valid,
    input  logic [31:0] i_imem_resp_data,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);
    localparam int unsigned PW      = $clog2(DEPTH);
    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   inst_mem_q [DEPTH];

    logic [31:0] redirect_pc;
    logic [CW:0] reserved;
    logic        fifo_empty, accept, resp_live, bypass, push, pop;

    assign redirect_pc = i_redirect_pc & 32'hFFFF_FFFC;
    assign fifo_empty  = (count_q == '0);

    // Slots holding words plus slots promised to live in-flight responses; never exceeds DEPTH.
    assign reserved         = {1'b0, count_q} + {1'b0, out_q} - {1'b0, drop_q};
    assign o_imem_req_valid = !i_rst && !i_redirect && ({1'b0, out_q} < DEPTH_W) && (reserved < DEPTH_W);
    assign o_imem_req_addr  = fetch_pc_q;
    assign accept           = o_imem_req_valid && i_imem_req_ready;
    assign resp_live        = i_imem_resp_valid && (drop_q == '0) && !i_redirect;

`ifdef FETCH_BYPASS_EN
    assign bypass       = resp_live && fifo_empty && !i_rst;
    assign o_inst_valid = !fifo_empty || bypass;
    assign o_inst       = bypass ? i_imem_resp_data : inst_mem_q[rd_ptr_q];
    assign o_inst_pc    = bypass ? resp_pc_q : pc_mem_q[rd_ptr_q];
`else
    assign bypass       = 1'b0;
    assign o_inst_valid = !fifo_empty;
    assign o_inst       = inst_mem_q[rd_ptr_q];
    assign o_inst_pc    = pc_mem_q[rd_ptr_q];
`endif

    assign push = resp_live && !(bypass && i_inst_ready);
    assign pop  = !fifo_empty && i_inst_ready && !i_redirect;

    always_comb begin
        // NOTE: every next-state signal is defaulted first so no path leaves it unassigned and infers a latch.
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        out_d      = out_q + CW'(accept) - CW'(i_imem_resp_valid);
        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (i_redirect) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            drop_d     = out_q - CW'(i_imem_resp_valid);
        end else begin
            if (i_imem_resp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (resp_live) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc_q <= RESET_ADDR;
            resp_pc_q  <= RESET_ADDR;
            count_q    <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            // NOTE: storage is reset because o_inst/o_inst_pc read it directly and must leave reset as zero.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (push) begin
                pc_mem_q[wr_ptr_q]   <= resp_pc_q;
                inst_mem_q[wr_ptr_q] <= i_imem_resp_data;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based fetch model plus a bench-side in-order memory.
// Honours FETCH_BYPASS_EN when the same macro is defined for the build.
module tb_fetch_unit;
    localparam logic [31:0] RST_ADDR = 32'h0000_0100;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst, req_ready, resp_valid, inst_ready, redirect;
    logic [31:0] resp_data, redirect_pc;
    logic        o_imem_req_valid, o_inst_valid;
    logic [31:0] o_imem_req_addr, o_inst, o_inst_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_ADDR(RST_ADDR), .DEPTH(DEPTH)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (req_ready),
        .o_imem_req_addr  (o_imem_req_addr),
        .i_imem_resp_valid(resp_valid),
        .i_imem_resp_data (resp_data),
        .o_inst_valid     (o_inst_valid),
        .i_inst_ready     (inst_ready),
        .o_inst           (o_inst),
        .o_inst_pc        (o_inst_pc),
        .i_redirect       (redirect),
        .i_redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memreq_t;

    entry_t      m_fifo[$];
    bit          m_flight[$];
    memreq_t     memq[$];
    logic [31:0] m_fetch_pc, m_resp_pc;
    int          cyc, mem_lat;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h0000_0013;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_flight.delete();
        memq.delete();
        m_fetch_pc = RST_ADDR;
        m_resp_pc  = RST_ADDR;
    endtask

    task automatic drive_mem();
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            resp_valid = 1'b1;
            resp_data  = inst_of(memq[0].addr);
        end else begin
            resp_valid = 1'b0;
            resp_data  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic settle();
        drive_mem();
        #1;
    endtask

    // One clock: compare DUT against the model at the falling edge, then advance the model.
    task automatic tick();
        bit     exp_req, exp_iv, byp, was_live, took;
        int     live;
        entry_t head;
        drive_mem();
        @(negedge clk);
        live = 0;
        foreach (m_flight[i]) live += int'(m_flight[i]);
        exp_req = !rst && !redirect && (m_flight.size() < DEPTH) && (m_fifo.size() + live < DEPTH);
        byp = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = !rst && !redirect && resp_valid && (m_fifo.size() == 0) && (live == m_flight.size());
`endif
        exp_iv = (m_fifo.size() > 0) || byp;
        if (m_fifo.size() > 0) head = m_fifo[0];
        else head = '{pc: m_resp_pc, inst: resp_data};

        check("req_valid", o_imem_req_valid, exp_req);
        if (exp_req) check("req_addr", o_imem_req_addr, m_fetch_pc);
        check("inst_valid", o_inst_valid, exp_iv);
        if (exp_iv) begin
            check("inst", o_inst, head.inst);
            check("inst_pc", o_inst_pc, head.pc);
        end

        if (rst) begin
            model_reset();
        end else begin
            was_live = 1'b0;
            if (resp_valid) begin
                void'(memq.pop_front());
                was_live = m_flight.pop_front();
            end
            if (redirect) begin
                m_fifo.delete();
                foreach (m_flight[i]) m_flight[i] = 1'b0;
                m_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
                m_resp_pc  = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                took = 1'b0;
                if (exp_iv && inst_ready) begin
                    if (m_fifo.size() > 0) void'(m_fifo.pop_front());
                    else took = 1'b1;
                end
                if (resp_valid && was_live) begin
                    if (!took) m_fifo.push_back('{pc: m_resp_pc, inst: resp_data});
                    m_resp_pc += 32'd4;
                end
                if (exp_req && req_ready) begin
                    memq.push_back('{addr: m_fetch_pc, due: cyc + mem_lat});
                    m_flight.push_back(1'b1);
                    m_fetch_pc += 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        redirect   = 1'b0;
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [47:0] rr_pat;
        logic [47:0] ir_pat;
        bit          found;
        rr_pat      = 48'hF7DE_FBBF_6FDF;
        ir_pat      = 48'hDB6D_F3CF_7EED;
        rst         = 1'b1;
        req_ready   = 1'b1;
        inst_ready  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        resp_valid  = 1'b0;
        resp_data   = 32'h0;
        mem_lat     = 1;
        cyc         = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        settle();
        check("rst_req_valid", o_imem_req_valid, 32'd0);
        check("rst_inst_valid", o_inst_valid, 32'd0);
        check("rst_req_addr", o_imem_req_addr, 32'h0000_0100);
        check("rst_inst", o_inst, 32'h0);
        check("rst_inst_pc", o_inst_pc, 32'h0);

        // Streaming: memory always ready, 1-cycle latency, decode always ready.
        rst = 1'b0;
        settle();
        check("first_req_valid", o_imem_req_valid, 32'd1);
        check("first_req_addr", o_imem_req_addr, 32'h0000_0100);
        tick();
        settle();
`ifdef FETCH_BYPASS_EN
        check("bypass_valid_N", o_inst_valid, 32'd1);
        check("bypass_inst_N", o_inst, 32'h0000_0113);
        check("bypass_pc_N", o_inst_pc, 32'h0000_0100);
`else
        check("fifo_valid_N", o_inst_valid, 32'd0);
`endif
        tick();
`ifndef FETCH_BYPASS_EN
        settle();
        check("cycle3_valid", o_inst_valid, 32'd1);
        check("cycle3_pc", o_inst_pc, 32'h0000_0100);
        check("cycle3_inst", o_inst, 32'h0000_0113);
`endif
        repeat (12) tick();

        // Decode stall: two requests fill the FIFO, requests stop, head holds.
        do_reset();
        inst_ready = 1'b0;
        repeat (8) tick();
        settle();
        check("stall_req_valid", o_imem_req_valid, 32'd0);
        check("stall_inst_valid", o_inst_valid, 32'd1);
        check("stall_inst_pc", o_inst_pc, 32'h0000_0100);
        inst_ready = 1'b1;
        repeat (10) tick();

        // Memory not ready: address holds at the reset PC.
        do_reset();
        req_ready = 1'b0;
        repeat (5) tick();
        settle();
        check("memstall_req_valid", o_imem_req_valid, 32'd1);
        check("memstall_req_addr", o_imem_req_addr, 32'h0000_0100);
        check("memstall_inst_valid", o_inst_valid, 32'd0);
        req_ready = 1'b1;
        repeat (8) tick();

        // Redirect with two requests in flight on a 3-cycle memory.
        do_reset();
        mem_lat = 3;
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        tick();
        redirect = 1'b0;
        tick();
        settle();
        check("redir_req_valid", o_imem_req_valid, 32'd1);
        check("redir_req_addr", o_imem_req_addr, 32'h0000_0200);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            settle();
            if (o_inst_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("redir_inst_seen", 32'(found), 32'd1);
        check("redir_first_pc", o_inst_pc, 32'h0000_0200);
        repeat (6) tick();

        // Redirect coincident with a response while decode is ready.
        mem_lat = 1;
        repeat (6) tick();
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            settle();
            if (resp_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("coinc_resp_seen", 32'(found), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0000;
        tick();
        redirect = 1'b0;
        settle();
        check("coinc_flushed", o_inst_valid, 32'd0);
        tick();
        settle();
`ifdef FETCH_BYPASS_EN
        check("coinc_R2_valid", o_inst_valid, 32'd1);
        check("coinc_R2_inst", o_inst, 32'h0000_0013);
`else
        check("coinc_R2_valid", o_inst_valid, 32'd0);
        tick();
        settle();
        check("coinc_R3_valid", o_inst_valid, 32'd1);
        check("coinc_R3_inst", o_inst, 32'h0000_0013);
        check("coinc_R3_pc", o_inst_pc, 32'h0000_0000);
`endif
        repeat (4) tick();

        // Mixed backpressure on a 2-cycle memory, including a redirect that wraps the PC.
        mem_lat = 2;
        for (int i = 0; i < 48; i++) begin
            req_ready   = rr_pat[i];
            inst_ready  = ir_pat[i];
            redirect    = (i == 17) || (i == 35);
            redirect_pc = (i == 17) ? 32'hFFFF_FFFA : 32'h0000_1006;
            tick();
        end
        redirect   = 1'b0;
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
